// File: rtl/cv32e40p_instr_realigner.sv
// cv32e40p_instr_realigner
// Converts word-aligned 32-bit fetch words into one instruction per transfer.
// Realigns 32-bit instructions that straddle a word boundary and splits words
// that carry 16-bit RVC instructions. Tracks the PC of the presented instruction.
// Build option: define CV32E40P_RVC_EN to enable compressed-instruction support.
// Without it, every fetch word is treated as one 32-bit instruction.
module cv32e40p_instr_realigner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o
);

`ifdef CV32E40P_RVC_EN

  typedef enum logic [1:0] {
    ALIGNED,
    MISALIGNED,
    BRANCH_MIS
  } state_e;

  state_e      state;
  state_e      state_nxt;
  logic [31:0] pc;
  logic [15:0] r;

  logic        valid;
  logic        rdy;
  logic        cmp;
  logic        adv;
  logic        r_ld;
  logic [31:0] instr;
  logic [31:0] pc_step;

  // Halfword-aligned targets only; bit 0 of the branch address carries nothing.
  logic        unused_addr_bit;
  assign unused_addr_bit = branch_addr_i[0];

  // Decode the instruction at pc from the residual halfword and the fetch word.
  // adv marks a cycle in which state/pc/r move: a transfer, or the discard pop
  // of a word whose upper half starts a 32-bit instruction after a branch.
  always_comb begin
    valid     = 1'b0;
    rdy       = 1'b0;
    cmp       = 1'b0;
    adv       = 1'b0;
    r_ld      = 1'b0;
    instr     = '0;
    pc_step   = 32'd4;
    state_nxt = state;
    case (state)
      ALIGNED: begin
        valid = fetch_valid_i;
        rdy   = fetch_valid_i & instr_ready_i;
        adv   = rdy;
        if (fetch_rdata_i[1:0] == 2'b11) begin
          instr = fetch_rdata_i;
        end else begin
          instr     = {16'h0000, fetch_rdata_i[15:0]};
          cmp       = 1'b1;
          pc_step   = 32'd2;
          r_ld      = 1'b1;
          state_nxt = MISALIGNED;
        end
      end
      MISALIGNED: begin
        if (r[1:0] != 2'b11) begin
          instr     = {16'h0000, r};
          cmp       = 1'b1;
          valid     = 1'b1;
          pc_step   = 32'd2;
          adv       = instr_ready_i;
          state_nxt = ALIGNED;
        end else begin
          instr = {fetch_rdata_i[15:0], r};
          valid = fetch_valid_i;
          rdy   = fetch_valid_i & instr_ready_i;
          adv   = rdy;
          r_ld  = 1'b1;
        end
      end
      BRANCH_MIS: begin
        if (fetch_rdata_i[17:16] != 2'b11) begin
          instr     = {16'h0000, fetch_rdata_i[31:16]};
          cmp       = 1'b1;
          valid     = fetch_valid_i;
          rdy       = fetch_valid_i & instr_ready_i;
          adv       = rdy;
          pc_step   = 32'd2;
          state_nxt = ALIGNED;
        end else begin
          // Lower half lies before the target: pop the word, keep the upper half.
          rdy       = fetch_valid_i;
          adv       = rdy;
          pc_step   = '0;
          r_ld      = 1'b1;
          state_nxt = MISALIGNED;
        end
      end
      default: begin
        state_nxt = ALIGNED;
      end
    endcase
    if (rst || branch_i) begin
      valid = 1'b0;
      rdy   = 1'b0;
      adv   = 1'b0;
    end
    if (!valid) begin
      instr = '0;
      cmp   = 1'b0;
    end
  end

  // State, pc and residual halfword; reset beats branch, branch beats transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALIGNED;
      pc    <= RESET_PC;
      r     <= '0;
    end else if (branch_i) begin
      pc    <= {branch_addr_i[31:1], 1'b0};
      r     <= '0;
      state <= branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
    end else if (adv) begin
      pc    <= pc + pc_step;
      state <= state_nxt;
      if (r_ld) begin
        r <= fetch_rdata_i[31:16];
      end
    end
  end

  // Drive the ports from the decode results.
  always_comb begin
    instr_valid_o      = valid;
    fetch_ready_o      = rdy;
    instr_aligned_o    = instr;
    instr_compressed_o = cmp;
    pc_o               = pc;
  end

`else

  logic [31:0] pc;
  logic        valid;

  // Word-aligned targets only in this build.
  logic [1:0]  unused_addr_bits;
  assign unused_addr_bits = branch_addr_i[1:0];

  // Every fetch word is one 32-bit instruction, passed straight through.
  always_comb begin
    valid              = fetch_valid_i & ~branch_i & ~rst;
    instr_valid_o      = valid;
    fetch_ready_o      = instr_ready_i & ~branch_i & ~rst;
    instr_aligned_o    = valid ? fetch_rdata_i : '0;
    instr_compressed_o = 1'b0;
    pc_o               = pc;
  end

  // Program counter: word steps, word-aligned branch targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_i) begin
      pc <= {branch_addr_i[31:2], 2'b00};
    end else if (valid && instr_ready_i) begin
      pc <= pc + 32'd4;
    end
  end

`endif

endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// Bench for cv32e40p_instr_realigner. The reference treats program memory as a
// halfword array: the instruction at pc is decoded from memory, and it may be
// presented once all of its halfwords have reached the realigner.
module tb_cv32e40p_instr_realigner;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_aligned_o;
  logic        instr_compressed_o;
  logic [31:0] pc_o;

  cv32e40p_instr_realigner #(.RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_rdata_i      (fetch_rdata_i),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_aligned_o    (instr_aligned_o),
    .instr_compressed_o (instr_compressed_o),
    .pc_o               (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        c;
  } xfer_t;

  logic [15:0] mem [256];
  xfer_t       log_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mpc;
  logic [31:0] fa;
  logic        held;

  logic [31:0] d_pc [8];
  logic [31:0] d_in [8];
  logic        d_c  [8];
  int          d_n;

  function automatic logic [15:0] rd(input logic [31:0] a);
    return mem[a[8:1]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, update the model.
  task automatic cycle(input logic r_i, input logic fv_req, input logic rdy,
                       input logic br, input logic [31:0] ba);
    logic [15:0] hw;
    logic [31:0] exp_i;
    logic        exp_c;
    logic [31:0] sz;
    logic        ev;
    logic        er;
    logic        pop;
`ifdef CV32E40P_RVC_EN
    logic        resid;
    logic        cov0;
    logic        cov1;
    logic        touches;
`endif
    rst           = r_i;
    branch_i      = br;
    branch_addr_i = ba;
    instr_ready_i = rdy;
    fetch_valid_i = fv_req | held;
    fetch_rdata_i = {rd(fa + 32'd2), rd(fa)};
`ifdef CV32E40P_RVC_EN
    hw = rd(mpc);
    if (hw[1:0] != 2'b11) begin
      exp_i = {16'h0000, hw}; exp_c = 1'b1; sz = 32'd2;
    end else begin
      exp_i = {rd(mpc + 32'd2), hw}; exp_c = 1'b0; sz = 32'd4;
    end
    resid   = (fa == ((mpc & 32'hFFFF_FFFC) + 32'd4));
    cov0    = (fetch_valid_i && ((mpc & 32'hFFFF_FFFC) == fa)) ||
              (resid && (mpc == fa - 32'd2));
    cov1    = (fetch_valid_i && (((mpc + 32'd2) & 32'hFFFF_FFFC) == fa));
    ev      = !r_i && !br && cov0 && (sz == 32'd2 || cov1);
    touches = ((mpc & 32'hFFFF_FFFC) == fa) ||
              (sz == 32'd4 && (((mpc + 32'd2) & 32'hFFFF_FFFC) == fa));
    er      = !r_i && !br && fetch_valid_i && (ev ? (rdy && touches) : 1'b1);
`else
    hw    = rd(mpc);
    exp_i = {rd(mpc + 32'd2), hw};
    exp_c = 1'b0;
    sz    = 32'd4;
    ev    = !r_i && !br && fetch_valid_i;
    er    = !r_i && !br && rdy;
`endif
    @(negedge clk);
    if (!r_i) chk("pc", pc_o, mpc);
    chk("valid", 32'(instr_valid_o), 32'(ev));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(er));
    chk("instr", instr_aligned_o, ev ? exp_i : 32'h0);
    chk("compressed", 32'(instr_compressed_o), ev ? 32'(exp_c) : 32'h0);
    if (instr_valid_o && instr_ready_i)
      log_q.push_back('{pc_o, instr_aligned_o, instr_compressed_o});
    pop = fetch_valid_i && fetch_ready_o;
    @(posedge clk);
    #1;
    if (r_i) begin
      mpc = RST_PC; fa = RST_PC; held = 1'b0;
    end else if (br) begin
`ifdef CV32E40P_RVC_EN
      mpc = ba & 32'hFFFF_FFFE;
`else
      mpc = ba & 32'hFFFF_FFFC;
`endif
      fa = ba & 32'hFFFF_FFFC; held = 1'b0;
    end else begin
      if (ev && rdy) mpc = mpc + sz;
      if (pop) fa = fa + 32'd4;
      held = fetch_valid_i && !pop;
    end
  endtask

  task automatic check_log(input string pre);
    chk({pre, "_count_min"}, 32'(log_q.size() >= d_n), 32'd1);
    for (int i = 0; i < d_n; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("%s_pc%0d", pre, i), log_q[i].pc, d_pc[i]);
        chk($sformatf("%s_in%0d", pre, i), log_q[i].instr, d_in[i]);
        chk($sformatf("%s_c%0d", pre, i), 32'(log_q[i].c), 32'(d_c[i]));
      end
    end
  endtask

  initial begin
    mpc = RST_PC; fa = RST_PC; held = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
    mem[8'h40] = 16'h0413; mem[8'h41] = 16'h0000;
    mem[8'h42] = 16'h0513; mem[8'h43] = 16'h0085;
    mem[8'h44] = 16'h4501; mem[8'h45] = 16'h4505;
    mem[8'h46] = 16'h4501; mem[8'h47] = 16'h0413;
    mem[8'h48] = 16'h0000; mem[8'h49] = 16'h4581;
    mem[8'h80] = 16'h1234; mem[8'h81] = 16'h4585;
    mem[8'h82] = 16'h4501; mem[8'h83] = 16'h0513; mem[8'h84] = 16'h0085;

    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("reset_pc", pc_o, 32'h0000_0080);

    // Straight-line code: full words, RVC pairs and a straddling instruction.
    log_q.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
`ifdef CV32E40P_RVC_EN
    d_n = 8;
    d_pc = '{32'h80, 32'h84, 32'h88, 32'h8a, 32'h8c, 32'h8e, 32'h92, 32'h94};
    d_in = '{32'h0000_0413, 32'h0085_0513, 32'h0000_4501, 32'h0000_4505,
             32'h0000_4501, 32'h0000_0413, 32'h0000_4581, 32'h0000_0001};
    d_c  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    d_n = 6;
    d_pc = '{32'h80, 32'h84, 32'h88, 32'h8c, 32'h90, 32'h94, 32'h98, 32'h9c};
    d_in = '{32'h0000_0413, 32'h0085_0513, 32'h4505_4501, 32'h0413_4501,
             32'h4581_0000, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001};
    d_c  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    check_log("seq");

    // Branch to a halfword target (bit 0 set, ignored), stall 3 cycles, then take it.
    log_q.delete();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("stall_count", 32'(log_q.size()), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    d_n = 1;
`ifdef CV32E40P_RVC_EN
    d_pc[0] = 32'h102; d_in[0] = 32'h0000_4585; d_c[0] = 1'b1;
`else
    d_pc[0] = 32'h100; d_in[0] = 32'h4585_1234; d_c[0] = 1'b0;
`endif
    check_log("br");

    // Leave a 32-bit residual pending, starve the fetch, then reset mid-straddle.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
`ifdef CV32E40P_RVC_EN
    chk("starve_pc", pc_o, 32'h106);
`else
    chk("starve_pc", pc_o, 32'h108);
`endif
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("rst_mid_pc", pc_o, 32'h0000_0080);
    chk("rst_mid_valid", 32'(instr_valid_o), 32'd0);

    // Randomised program, handshakes, branches (including wrap) and resets.
    for (int i = 0; i < 256; i++) begin
      logic [15:0] hw;
      hw = 16'($urandom);
      if ($urandom_range(0, 1) == 0) hw[1:0] = 2'b11;
      else if (hw[1:0] == 2'b11) hw[1:0] = 2'b01;
      mem[i] = hw;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      logic        r_i;
      logic        br;
      logic [31:0] ba;
      r_i = ($urandom_range(0, 300) == 0);
      br  = !r_i && ($urandom_range(0, 40) == 0);
      ba  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      cycle(r_i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, br, ba);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_realigner.md
# cv32e40p_instr_realigner

Downstream consumer of the prefetch buffer's fetch handshake. Turns the stream of word-aligned 32-bit fetch words into one instruction per transfer, realigning 32-bit instructions that straddle a word boundary and splitting words that hold RVC (16-bit) instructions. Tracks the program counter of the presented instruction and feeds the IF/ID pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0080, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  fetch word available.
- fetch_ready_o  out  1  pop current fetch word.
- fetch_rdata_i  in  32  fetch word; bits [15:0] are the lower address halfword.
- branch_i  in  1  redirect; upstream flushes in the same cycle.
- branch_addr_i  in  32  redirect target, halfword aligned (bit 0 ignored).
- instr_valid_o  out  1  instruction presented.
- instr_ready_i  in  1  consumer accepts instruction.
- instr_aligned_o  out  32  instruction; compressed ones in [15:0], upper half zero.
- instr_compressed_o  out  1  presented instruction is 16-bit.
- pc_o  out  32  address of presented instruction.

## Operation
- Registers: state, pc (32), residual halfword r (16).
- An instruction is compressed iff its low bits [1:0] != 2'b11.
- Transfer = instr_valid_o & instr_ready_i; on transfer pc += 2 (compressed) or 4.
- ALIGNED (pc[1]=0, r empty):
  - valid = fetch_valid_i; W = fetch_rdata_i.
  - W[1:0]==11: output W; fetch_ready_o = instr_ready_i; stay.
  - else: output {16'h0,W[15:0]}; fetch_ready_o = instr_ready_i; on transfer r <= W[31:16], go MISALIGNED.
- MISALIGNED (pc[1]=1, r holds halfword at pc):
  - r[1:0]!=11: output {16'h0,r}, valid=1 without fetch, fetch_ready_o=0; on transfer go ALIGNED.
  - else: output {W[15:0],r}, valid = fetch_valid_i, fetch_ready_o = instr_ready_i; on transfer r <= W[31:16], stay.
- BRANCH_MIS (after branch with addr[1]=1; target is W[31:16]):
  - W[17:16]!=11: output {16'h0,W[31:16]}, valid=fetch_valid_i, fetch_ready_o=instr_ready_i; on transfer go ALIGNED.
  - else: instr_valid_o=0, fetch_ready_o=fetch_valid_i (discard pop); on pop r <= W[31:16], go MISALIGNED.
- branch_i has priority over everything: instr_valid_o=0, fetch_ready_o=0 that cycle; next pc <= {branch_addr_i[31:1],1'b0}, r cleared, state = ALIGNED if addr[1]=0 else BRANCH_MIS.

## Timing
- Zero-latency fall-through: outputs are combinational from registered state, r, pc and fetch inputs; no extra cycle per instruction.
- instr_valid_o never depends on instr_ready_i; fetch_ready_o may depend on instr_ready_i.
- Once asserted, instr_valid_o and instr_aligned_o stay stable until transfer or branch_i.
- Reset (any cycle, including mid-straddle): next edge state=ALIGNED, pc=RESET_PC, r=0; during and after reset instr_valid_o=0, fetch_ready_o=0 until fetch_valid_i; instr_compressed_o=0, instr_aligned_o=0 while not valid.
- Simultaneous branch_i and transfer: branch wins, no transfer counted, pc takes target.
- pc wraps modulo 2^32.
- Empty fetch in MISALIGNED with 32-bit residual: hold, valid=0, r/pc unchanged.

## Configuration
- CV32E40P_RVC_EN defined: full behaviour above.
- Undefined: only ALIGNED exists; every word output as 32-bit, instr_compressed_o tied 0, fetch_ready_o = instr_ready_i & ~branch_i, r not implemented, branch target pc <= {branch_addr_i[31:2],2'b00}, pc += 4 per transfer.

## Test plan
- Reset, then words 32'h0000_0413, 32'h0085_0513 with instr_ready_i=1 -> two transfers, pc 0x80 then 0x84, compressed=0, one pop each.
- Word 32'h4505_4501 (two RVC) -> instr 0x0000_4501 pc 0x80, then 0x0000_4505 pc 0x82 with no pop on second.
- Word 32'h0413_4501 then 32'hXXXX_0000 -> RVC 0x4501 at 0x80, then straddled 32'h0000_0413 at 0x82, r <= upper half of second word.
- branch_i with branch_addr_i=0x0000_0102, word 32'h4585_xxxx -> lower half dropped, instr 0x0000_4585 pc 0x102, next state ALIGNED.
- instr_ready_i held 0 for 3 cycles with valid word -> outputs stable, fetch_ready_o=0, pc unchanged; rst pulse mid-straddle -> pc=0x80, valid=0 next cycle.
